csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csru_pkg.sv | 27 ++
 rtl/csru_if.sv | 55 +++++
 rtl/csru_operand.sv | 23 ++
 rtl/csr_unit.sv | 164 ++++++++++++++++
 tb/tb_csr_unit.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csru_pkg.sv
// Shared types and constants for the CSR execution unit (csr_unit).
package csru_pkg;

    localparam int ROB_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_COMMIT,
        S_ISSUE,
        S_WAIT_DONE,
        S_WB
    } csru_state_e;

    // funct3[2] selects the zimm operand, funct3[1:0] is the CSR-file opcode
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [1:0] CSR_OP_ILLEGAL = 2'b00;
    localparam logic [1:0] CSR_OP_RW      = 2'b01;
    localparam logic [1:0] CSR_OP_RS      = 2'b10;
    localparam logic [1:0] CSR_OP_RC      = 2'b11;

endpackage

// File: rtl/csru_if.sv
// Bus bundle of the CSR unit: uop issue, ROB commit/flush, CSR-file port and writeback.
interface csru_if
    import csru_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEFAULT
);
    logic             csru_valid_i;
    logic [ROB_W-1:0] csru_rob_id_i;
    logic [2:0]       csru_funct3_i;
    logic [11:0]      csru_addr_i;
    logic [31:0]      csru_rs1_data_i;
    logic [4:0]       csru_zimm_i;
    logic             csru_rs1_zero_i;
    logic [5:0]       csru_dest_i;
    logic             csru_ready_o;

    logic             rob_oldest_valid_i;
    logic [ROB_W-1:0] rob_oldest_id_i;
    logic             flush_i;

    logic             csr_valid_o;
    logic [11:0]      csr_address_o;
    logic [1:0]       csr_opcode_o;
    logic             csr_wr_en_o;
    logic [31:0]      csr_data_o;
    logic             csr_done_i;
    logic             csr_excp_i;
    logic [31:0]      csr_rdata_i;

    logic             wb_valid_o;
    logic [5:0]       wb_dest_o;
    logic [31:0]      wb_data_o;
    logic [ROB_W-1:0] wb_rob_id_o;
    logic             wb_excp_o;
    logic             redirect_o;

    modport slave (
        input  csru_valid_i, csru_rob_id_i, csru_funct3_i, csru_addr_i, csru_rs1_data_i,
               csru_zimm_i, csru_rs1_zero_i, csru_dest_i,
               rob_oldest_valid_i, rob_oldest_id_i, flush_i,
               csr_done_i, csr_excp_i, csr_rdata_i,
        output csru_ready_o, csr_valid_o, csr_address_o, csr_opcode_o, csr_wr_en_o, csr_data_o,
               wb_valid_o, wb_dest_o, wb_data_o, wb_rob_id_o, wb_excp_o, redirect_o
    );

    modport master (
        output csru_valid_i, csru_rob_id_i, csru_funct3_i, csru_addr_i, csru_rs1_data_i,
               csru_zimm_i, csru_rs1_zero_i, csru_dest_i,
               rob_oldest_valid_i, rob_oldest_id_i, flush_i,
               csr_done_i, csr_excp_i, csr_rdata_i,
        input  csru_ready_o, csr_valid_o, csr_address_o, csr_opcode_o, csr_wr_en_o, csr_data_o,
               wb_valid_o, wb_dest_o, wb_data_o, wb_rob_id_o, wb_excp_o, redirect_o
    );

endinterface

// File: rtl/csru_operand.sv
// Turns a latched CSR uop into CSR-file opcode, write data and write enable.
module csru_operand
    import csru_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1_data,
    input  logic [4:0]  i_zimm,
    input  logic        i_rs1_zero,
    output logic [1:0]  o_opcode,
    output logic [31:0] o_data,
    output logic        o_wr_en,
    output logic        o_illegal
);

    // Set/clear with a zero mask must not write, so side-effect-free reads stay reads
    always_comb begin
        o_opcode  = i_funct3[1:0];
        o_data    = i_funct3[2] ? {27'd0, i_zimm} : i_rs1_data;
        o_wr_en   = (i_funct3[1:0] == CSR_OP_RW) ? 1'b1 : !i_rs1_zero;
        o_illegal = (i_funct3[1:0] == CSR_OP_ILLEGAL);
    end

endmodule

// File: rtl/csr_unit.sv
// Executes CSR uops non-speculatively: waits for ROB commit, issues to the CSR file, writes back.
// Optional CSRU_TIMEOUT_EN: abort a CSR access with an exception after 15 cycles without done.
module csr_unit
    import csru_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEFAULT
) (
    input logic  cpu_clock_i,
    input logic  cpu_reset_i,
    csru_if.slave bus
);

    csru_state_e      r_state;
    csru_state_e      w_next_state;
    logic [ROB_W-1:0] r_rob_id;
    logic [2:0]       r_funct3;
    logic [11:0]      r_addr;
    logic [31:0]      r_rs1_data;
    logic [4:0]       r_zimm;
    logic             r_rs1_zero;
    logic [5:0]       r_dest;
    logic [31:0]      r_rdata;
    logic             r_excp;

    logic [1:0]       w_opcode;
    logic [31:0]      w_data;
    logic             w_wr_en;
    logic             w_illegal;
    logic             w_commit;
    logic             w_timeout;

    csru_operand u_operand (
        .i_funct3   (r_funct3),
        .i_rs1_data (r_rs1_data),
        .i_zimm     (r_zimm),
        .i_rs1_zero (r_rs1_zero),
        .o_opcode   (w_opcode),
        .o_data     (w_data),
        .o_wr_en    (w_wr_en),
        .o_illegal  (w_illegal)
    );

    assign w_commit = bus.rob_oldest_valid_i && (bus.rob_oldest_id_i == r_rob_id);

`ifdef CSRU_TIMEOUT_EN
    logic [3:0] r_timer;

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i || (r_state != S_WAIT_DONE)) begin
            r_timer <= 4'd0;
        end else begin
            r_timer <= r_timer + 4'd1;
        end
    end

    // The 15th consecutive WAIT_DONE cycle without done gives up
    assign w_timeout = (r_state == S_WAIT_DONE) && !bus.csr_done_i && (r_timer == 4'd14);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush only matters before commit; once committed the uop must complete
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.csru_valid_i) w_next_state = S_WAIT_COMMIT;
            end
            S_WAIT_COMMIT: begin
                if (bus.flush_i)   w_next_state = S_IDLE;
                else if (w_commit) w_next_state = w_illegal ? S_WB : S_ISSUE;
            end
            S_ISSUE:     w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.csr_done_i || w_timeout) w_next_state = S_WB;
            end
            S_WB:        w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            r_rob_id   <= '0;
            r_funct3   <= 3'd0;
            r_addr     <= 12'd0;
            r_rs1_data <= 32'd0;
            r_zimm     <= 5'd0;
            r_rs1_zero <= 1'b0;
            r_dest     <= 6'd0;
            r_rdata    <= 32'd0;
            r_excp     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.csru_valid_i) begin
                        r_rob_id   <= bus.csru_rob_id_i;
                        r_funct3   <= bus.csru_funct3_i;
                        r_addr     <= bus.csru_addr_i;
                        r_rs1_data <= bus.csru_rs1_data_i;
                        r_zimm     <= bus.csru_zimm_i;
                        r_rs1_zero <= bus.csru_rs1_zero_i;
                        r_dest     <= bus.csru_dest_i;
                    end
                end
                S_WAIT_COMMIT: begin
                    if (!bus.flush_i && w_commit && w_illegal) begin
                        r_rdata <= 32'd0;
                        r_excp  <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.csr_done_i) begin
                        r_rdata <= bus.csr_rdata_i;
                        r_excp  <= bus.csr_excp_i;
                    end else if (w_timeout) begin
                        r_rdata <= 32'd0;
                        r_excp  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output fields read zero outside the phase in which they carry meaning
    always_comb begin
        bus.csru_ready_o  = (r_state == S_IDLE);
        bus.csr_valid_o   = (r_state == S_ISSUE);
        bus.csr_address_o = 12'd0;
        bus.csr_opcode_o  = 2'd0;
        bus.csr_wr_en_o   = 1'b0;
        bus.csr_data_o    = 32'd0;
        bus.wb_valid_o    = (r_state == S_WB);
        bus.wb_dest_o     = 6'd0;
        bus.wb_data_o     = 32'd0;
        bus.wb_rob_id_o   = '0;
        bus.wb_excp_o     = 1'b0;
        bus.redirect_o    = 1'b0;
        if ((r_state == S_ISSUE) || (r_state == S_WAIT_DONE)) begin
            bus.csr_address_o = r_addr;
            bus.csr_opcode_o  = w_opcode;
            bus.csr_wr_en_o   = w_wr_en;
            bus.csr_data_o    = w_data;
        end
        if (r_state == S_WB) begin
            bus.wb_dest_o   = r_dest;
            bus.wb_data_o   = r_rdata;
            bus.wb_rob_id_o = r_rob_id;
            bus.wb_excp_o   = r_excp;
            bus.redirect_o  = w_wr_en && !r_excp;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit with an expectation-queue model and a per-cycle compare process.
// Define CSRU_TIMEOUT_EN to also exercise the CSR-access timeout.
`timescale 1ns/1ps
module tb_csr_unit;
    import csru_pkg::*;

    localparam int ROB_W = 5;

    localparam int MODE_NORMAL       = 0;
    localparam int MODE_FLUSH_COMMIT = 1;
    localparam int MODE_FLUSH_DONE   = 2;
    localparam int MODE_TIMEOUT      = 3;
    localparam int MODE_RESET        = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    csru_if #(.ROB_W(ROB_W)) bus ();

    csr_unit #(.ROB_W(ROB_W)) dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic        wrEn;
        logic [31:0] data;
    } issue_t;

    typedef struct {
        logic [5:0]       dest;
        logic [31:0]      data;
        logic             checkData;
        logic [ROB_W-1:0] rob;
        logic             excp;
        logic             redirect;
    } wb_t;

    issue_t issueQ[$];
    wb_t    wbQ[$];
    int     vectors = 0;
    int     miscompares = 0;

    logic [93:0] allOut;
    assign allOut = {bus.csr_valid_o, bus.csr_address_o, bus.csr_opcode_o, bus.csr_wr_en_o,
                     bus.csr_data_o, bus.wb_valid_o, bus.wb_dest_o, bus.wb_data_o,
                     bus.wb_rob_id_o, bus.wb_excp_o, bus.redirect_o};

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // What the CSR file must see, derived from the instruction encoding alone
    function automatic issue_t modelIssue(input logic [2:0] f3, input logic [11:0] addr,
                                          input logic [31:0] rs1, input logic [4:0] zimm,
                                          input logic rz);
        issue_t m;
        int kind;
        kind   = int'(f3) % 4;
        m.addr = addr;
        m.op   = 2'(kind);
        m.data = (int'(f3) >= 4) ? 32'(zimm) : rs1;
        m.wrEn = (kind == 1) || !rz;
        return m;
    endfunction

    // Compare process: every CSR-file pulse and writeback is matched against the queues
    issue_t curIssue;
    logic   inFlight = 1'b0;
    logic   prevCsrValid = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            inFlight = 1'b0;
        end else begin
            if (bus.csr_valid_o) begin
                if (prevCsrValid) checkOutput("csr_valid_single_cycle", 1, 0);
                if (issueQ.size() == 0) begin
                    checkOutput("unexpected_csr_valid", 1, 0);
                end else begin
                    curIssue = issueQ.pop_front();
                    checkOutput("csr_address", bus.csr_address_o, curIssue.addr);
                    checkOutput("csr_opcode", bus.csr_opcode_o, curIssue.op);
                    checkOutput("csr_wr_en", bus.csr_wr_en_o, curIssue.wrEn);
                    checkOutput("csr_data", bus.csr_data_o, curIssue.data);
                    inFlight = 1'b1;
                end
            end else if (inFlight && !bus.wb_valid_o) begin
                checkOutput("csr_fields_stable",
                            {bus.csr_address_o, bus.csr_opcode_o, bus.csr_wr_en_o, bus.csr_data_o},
                            {curIssue.addr, curIssue.op, curIssue.wrEn, curIssue.data});
            end
            if (bus.wb_valid_o) begin
                inFlight = 1'b0;
                if (wbQ.size() == 0) begin
                    checkOutput("unexpected_wb_valid", 1, 0);
                end else begin
                    wb_t e;
                    e = wbQ.pop_front();
                    checkOutput("wb_dest", bus.wb_dest_o, e.dest);
                    checkOutput("wb_rob_id", bus.wb_rob_id_o, e.rob);
                    checkOutput("wb_excp", bus.wb_excp_o, e.excp);
                    checkOutput("redirect", bus.redirect_o, e.redirect);
                    if (e.checkData) checkOutput("wb_data", bus.wb_data_o, e.data);
                end
            end else if (bus.redirect_o) begin
                checkOutput("redirect_without_wb", bus.redirect_o, 0);
            end
        end
        prevCsrValid = bus.csr_valid_o && !rst;
    end

    task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] rs1, input logic [4:0] zimm, input logic rz,
                                 input logic [5:0] dest, input logic [ROB_W-1:0] rob,
                                 input logic [31:0] rdata, input logic cexcp, input int mode);
        issue_t           iss;
        wb_t              w;
        logic             legal;
        logic             seenWb;
        logic [ROB_W-1:0] other;
        int               cyc;
        int               bound;
        int               expLat;

        iss         = modelIssue(f3, addr, rs1, zimm, rz);
        legal       = (int'(f3) % 4) != 0;
        w.dest      = dest;
        w.rob       = rob;
        w.excp      = !legal || cexcp || (mode == MODE_TIMEOUT);
        w.data      = (mode == MODE_TIMEOUT) ? 32'd0 : rdata;
        w.checkData = legal;
        w.redirect  = iss.wrEn && !w.excp;
        expLat      = !legal ? 1 : (mode == MODE_FLUSH_DONE) ? 4 : (mode == MODE_TIMEOUT) ? 17 : 3;

        @(posedge clk); #1;
        bus.csru_valid_i    = 1'b1;
        bus.csru_rob_id_i   = rob;
        bus.csru_funct3_i   = f3;
        bus.csru_addr_i     = addr;
        bus.csru_rs1_data_i = rs1;
        bus.csru_zimm_i     = zimm;
        bus.csru_rs1_zero_i = rz;
        bus.csru_dest_i     = dest;
        @(negedge clk);
        checkOutput("ready_in_idle", bus.csru_ready_o, 1);
        @(posedge clk); #1;
        bus.csru_valid_i    = 1'b0;
        bus.csru_rs1_data_i = ~rs1;
        bus.csru_addr_i     = ~addr;
        bus.csru_funct3_i   = 3'd0;
        bus.csru_zimm_i     = ~zimm;
        @(negedge clk);
        checkOutput("ready_busy", bus.csru_ready_o, 0);

        if (mode == MODE_FLUSH_COMMIT) begin
            @(posedge clk); #1;
            bus.flush_i            = 1'b1;
            bus.rob_oldest_valid_i = 1'b1;
            bus.rob_oldest_id_i    = rob;
            @(posedge clk); #1;
            bus.flush_i            = 1'b0;
            bus.rob_oldest_valid_i = 1'b0;
            @(negedge clk);
            checkOutput("ready_after_flush", bus.csru_ready_o, 1);
            repeat (4) @(negedge clk);
            return;
        end

        other = rob + 1'b1;
        @(posedge clk); #1;
        bus.rob_oldest_valid_i = 1'b1;
        bus.rob_oldest_id_i    = other;
        @(negedge clk);
        checkOutput("hold_on_rob_mismatch", {bus.csr_valid_o, bus.wb_valid_o, bus.csru_ready_o}, 0);
        if (legal) issueQ.push_back(iss);
        if (mode != MODE_RESET) wbQ.push_back(w);
        @(posedge clk); #1;
        bus.rob_oldest_id_i = rob;
        @(posedge clk);

        cyc    = 0;
        seenWb = 1'b0;
        bound  = (mode == MODE_RESET) ? 8 : 40;
        while (!seenWb && cyc < bound) begin
            #1;
            cyc++;
            bus.rob_oldest_valid_i = 1'b0;
            bus.flush_i            = 1'b0;
            bus.csr_done_i         = 1'b0;
            bus.csr_excp_i         = 1'b0;
            bus.csr_rdata_i        = 32'hBAD0_BAD0;
            if (legal && ((mode == MODE_NORMAL && cyc == 2) || (mode == MODE_FLUSH_DONE && cyc == 3))) begin
                bus.csr_done_i  = 1'b1;
                bus.csr_excp_i  = cexcp;
                bus.csr_rdata_i = rdata;
            end
            if (mode == MODE_FLUSH_DONE && cyc == 2) bus.flush_i = 1'b1;
            if (mode == MODE_RESET) rst = (cyc == 2);
            @(negedge clk);
            if (cyc == 1) checkOutput("issue_follows_commit", bus.csr_valid_o, legal);
            if (bus.wb_valid_o) seenWb = 1'b1;
            if (!seenWb) @(posedge clk);
        end

        if (mode != MODE_RESET) begin
            checkOutput("wb_within_bound", seenWb, 1);
            checkOutput("commit_to_wb_latency", cyc, expLat);
        end else begin
            checkOutput("no_wb_after_reset", seenWb, 0);
            checkOutput("ready_after_reset", bus.csru_ready_o, 1);
            checkOutput("outputs_zero_after_reset", allOut, 0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        issue_t pin;

        bus.csru_valid_i       = 1'b0;
        bus.csru_rob_id_i      = '0;
        bus.csru_funct3_i      = 3'd0;
        bus.csru_addr_i        = 12'd0;
        bus.csru_rs1_data_i    = 32'd0;
        bus.csru_zimm_i        = 5'd0;
        bus.csru_rs1_zero_i    = 1'b0;
        bus.csru_dest_i        = 6'd0;
        bus.rob_oldest_valid_i = 1'b0;
        bus.rob_oldest_id_i    = '0;
        bus.flush_i            = 1'b0;
        bus.csr_done_i         = 1'b0;
        bus.csr_excp_i         = 1'b0;
        bus.csr_rdata_i        = 32'd0;

        pin = modelIssue(F3_CSRRW, 12'h340, 32'hDEAD_BEEF, 5'd0, 1'b0);
        checkOutput("model_csrrw", {pin.op, pin.wrEn, pin.data}, {2'b01, 1'b1, 32'hDEAD_BEEF});
        pin = modelIssue(F3_CSRRCI, 12'h300, 32'hFFFF_FFFF, 5'd5, 1'b0);
        checkOutput("model_csrrci", {pin.op, pin.wrEn, pin.data}, {2'b11, 1'b1, 32'h0000_0005});
        pin = modelIssue(F3_CSRRS, 12'hC00, 32'd0, 5'd0, 1'b1);
        checkOutput("model_csrrs_zero", {pin.op, pin.wrEn}, {2'b10, 1'b0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("ready_during_reset", bus.csru_ready_o, 1);
        checkOutput("outputs_zero_during_reset", allOut, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset_release", bus.csru_ready_o, 1);

        applyStimulus(F3_CSRRW,  12'h340, 32'hDEAD_BEEF, 5'd0,  1'b0, 6'd10, 5'd3,  32'h1234_5678, 1'b0, MODE_NORMAL);
        applyStimulus(F3_CSRRS,  12'hC00, 32'h0000_0000, 5'd0,  1'b1, 6'd11, 5'd4,  32'h0000_AA55, 1'b0, MODE_NORMAL);
        applyStimulus(F3_CSRRCI, 12'h300, 32'hFFFF_FFFF, 5'd5,  1'b0, 6'd12, 5'd5,  32'h0000_1800, 1'b0, MODE_NORMAL);
        applyStimulus(F3_CSRRW,  12'h341, 32'h0BAD_F00D, 5'd0,  1'b0, 6'd13, 5'd6,  32'h5555_5555, 1'b0, MODE_FLUSH_COMMIT);
        applyStimulus(F3_CSRRSI, 12'h344, 32'h0000_0000, 5'd3,  1'b0, 6'd14, 5'd7,  32'hCAFE_0001, 1'b0, MODE_FLUSH_DONE);
        applyStimulus(3'b000,    12'h305, 32'h1111_1111, 5'd0,  1'b0, 6'd15, 5'd8,  32'h0,         1'b0, MODE_NORMAL);
        applyStimulus(3'b100,    12'h305, 32'h2222_2222, 5'd9,  1'b0, 6'd16, 5'd9,  32'h0,         1'b0, MODE_NORMAL);
        applyStimulus(F3_CSRRW,  12'h7C0, 32'h0000_00FF, 5'd0,  1'b0, 6'd17, 5'd10, 32'h8765_4321, 1'b1, MODE_NORMAL);
        applyStimulus(F3_CSRRC,  12'h300, 32'h0000_00F0, 5'd0,  1'b0, 6'd63, 5'd31, 32'hFFFF_FF0F, 1'b0, MODE_NORMAL);
        applyStimulus(F3_CSRRWI, 12'h340, 32'h0000_0000, 5'd0,  1'b1, 6'd1,  5'd0,  32'h0000_0042, 1'b0, MODE_NORMAL);
        applyStimulus(F3_CSRRW,  12'h341, 32'hA5A5_A5A5, 5'd0,  1'b0, 6'd20, 5'd12, 32'h0,         1'b0, MODE_RESET);
        applyStimulus(F3_CSRRS,  12'hF14, 32'h0000_0001, 5'd0,  1'b0, 6'd21, 5'd13, 32'h0000_0000, 1'b0, MODE_NORMAL);
`ifdef CSRU_TIMEOUT_EN
        applyStimulus(F3_CSRRW,  12'h342, 32'h1357_9BDF, 5'd0,  1'b0, 6'd22, 5'd14, 32'h0,         1'b0, MODE_TIMEOUT);
`endif

        repeat (3) @(negedge clk);
        checkOutput("issue_queue_drained", issueQ.size(), 0);
        checkOutput("wb_queue_drained", wbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
